// File: rtl/dice_roll_collector.sv
// dice_roll_collector: drives a dice roller a programmed number of times,
// range-checks each returned sample against the selected die, and
// accumulates total / maximum / error count over one transaction.
module dice_roll_collector #(
   parameter int unsigned RESP_LAT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  die_sel_in,
   input  logic [3:0]  count,
   output logic [1:0]  die_select,
   output logic        roll,
   input  logic [7:0]  rolled_number,
   output logic        busy,
   output logic        done,
   output logic [11:0] total,
   output logic [7:0]  max_roll,
   output logic [3:0]  err_count
);

   localparam logic [2:0] LAT_LOAD = 3'(RESP_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROLL,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  die_select_q, die_select_d;
   logic [3:0]  remain_q, remain_d;
   logic [2:0]  lat_q, lat_d;
   logic        roll_q, roll_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [11:0] total_q, total_d;
   logic [7:0]  max_roll_q, max_roll_d;
   logic [3:0]  err_count_q, err_count_d;

   logic [7:0]  sides;
   logic        sample_ok;

   // Number of faces of the latched die and validity of the current sample
   always_comb begin
      sides = 8'd4;
      case (die_select_q)
         2'b00:   sides = 8'd4;
         2'b01:   sides = 8'd6;
         2'b10:   sides = 8'd8;
         default: sides = 8'd20;
      endcase
      sample_ok = (rolled_number != '0) && (rolled_number <= sides);
   end

   // Next-state, accumulators and registered outputs derived from the next state
   always_comb begin
      state_d      = state_q;
      die_select_d = die_select_q;
      remain_d     = remain_q;
      lat_d        = lat_q;
      total_d      = total_q;
      max_roll_d   = max_roll_q;
      err_count_d  = err_count_q;

      case (state_q)
         S_IDLE: begin
            if (start && (count != '0)) begin
               die_select_d = die_sel_in;
               remain_d     = count;
               total_d      = '0;
               max_roll_d   = '0;
               err_count_d  = '0;
               state_d      = S_ROLL;
            end
         end
         S_ROLL: begin
            lat_d   = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == 3'd1) begin
               if (sample_ok) begin
                  total_d = total_q + {4'b0000, rolled_number};
                  if (rolled_number > max_roll_q) begin
                     max_roll_d = rolled_number;
                  end
               end else if (err_count_q != '1) begin
                  err_count_d = err_count_q + 4'd1;
               end
               remain_d = remain_q - 4'd1;
               state_d  = (remain_q == 4'd1) ? S_DONE : S_ROLL;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered: they reflect the state being entered
      roll_d = (state_d == S_ROLL);
      busy_d = (state_d == S_ROLL) || (state_d == S_WAIT);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         die_select_q <= '0;
         remain_q     <= '0;
         lat_q        <= '0;
         roll_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         total_q      <= '0;
         max_roll_q   <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         die_select_q <= die_select_d;
         remain_q     <= remain_d;
         lat_q        <= lat_d;
         roll_q       <= roll_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         total_q      <= total_d;
         max_roll_q   <= max_roll_d;
         err_count_q  <= err_count_d;
      end
   end

   assign die_select = die_select_q;
   assign roll       = roll_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign total      = total_q;
   assign max_roll   = max_roll_q;
   assign err_count  = err_count_q;

endmodule
